wave_sequencer: RTL and testbench

- Programmable scheduler for the lab waveform datapath; owns the shared 8-bit phase counter that drives the square, sawtooth and triangle shapes.
- Steps through a small program of slots. Each slot gives a waveform select, a clock divider and a period repeat count.
- Drives a single registered 8-bit sample bus (wave_out) toward the DAC / display path, plus status for the top-level FSM.

---
 rtl/wave_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_wave_sequencer.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wave_sequencer.sv
// rtl/wave_sequencer.sv - slot-programmed waveform scheduler driving a registered 8-bit sample bus
//
// Runs a small program of slots. Each slot word picks a shape, a clock divider
// and how many phase periods to play before moving on to the next slot.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   cfg_we        program slot write strobe
//   cfg_addr      slot written
//   cfg_data      slot word: [15:14] wave_sel, [13:8] repeat, [7:0] div
//   start         begin the program at slot 0 (level, ignored while busy)
//   stop          abort to IDLE, wins over start
//   loop          wrap to slot 0 after the last slot instead of finishing
//   busy          high in LOAD and RUN
//   done          one-cycle pulse on program completion
//   slot_idx      slot currently loaded or running
//   period_tick   one-cycle pulse when the phase wraps 255->0 in RUN
//   wave_out      registered sample, one cycle behind the phase register
module wave_sequencer #(
  parameter int DEPTH = 4,
  parameter int IDX_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_addr,
  input  logic [15:0]      cfg_data,
  input  logic             start,
  input  logic             stop,
  input  logic             loop,
  output logic             busy,
  output logic             done,
  output logic [IDX_W-1:0] slot_idx,
  output logic             period_tick,
  output logic [7:0]       wave_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [IDX_W-1:0] next_slot;
  logic             advance;

  logic [15:0]      prog [DEPTH];
  logic [15:0]      load_word;

  // Slot settings latched on LOAD so later config writes cannot disturb a running slot.
  logic [1:0]       wave_sel;
  logic [5:0]       rep;
  logic [7:0]       div;

  logic [7:0]       phase;
  logic [7:0]       div_cnt;
  logic [5:0]       period_cnt;

  logic             step_en;
  logic             wrap;
  logic             last_period;
  logic [7:0]       shape;

  assign load_word   = prog[slot_idx];
  assign step_en     = (div_cnt == div);
  assign wrap        = step_en && (phase == 8'd255);
  // period_cnt never exceeds rep-1 while running, so the 6-bit add cannot alias.
  assign last_period = wrap && ((period_cnt + 6'd1) == rep);

  always_comb begin
    shape = 8'd0;
    case (wave_sel)
      2'd0:    shape = 8'd0;
      2'd1:    shape = {8{phase[7]}};
      2'd2:    shape = phase;
      default: shape = (phase > 8'd128) ? (8'd0 - phase) : phase;
    endcase
  end

  always_comb begin
    next_state = state;
    next_slot  = slot_idx;
    advance    = 1'b0;
    case (state)
      IDLE: begin
        if (start && !stop) begin
          next_state = LOAD;
          next_slot  = '0;
        end
      end
      LOAD: begin
        if (stop) begin
          next_state = IDLE;
        end else if (load_word[13:8] != 6'd0) begin
          next_state = RUN;
        end else begin
          advance = 1'b1;
        end
      end
      RUN: begin
        if (stop) begin
          next_state = IDLE;
        end else if (last_period) begin
          advance = 1'b1;
        end
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase

    // Shared by an empty slot in LOAD and by the final period of a slot in RUN.
    if (advance) begin
      if (slot_idx != IDX_W'(DEPTH - 1)) begin
        next_state = LOAD;
        next_slot  = slot_idx + IDX_W'(1);
      end else if (loop) begin
        next_state = LOAD;
        next_slot  = '0;
      end else begin
        next_state = DONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        prog[i] <= 16'd0;
      end
      state       <= IDLE;
      slot_idx    <= '0;
      wave_sel    <= 2'd0;
      rep         <= 6'd0;
      div         <= 8'd0;
      phase       <= 8'd0;
      div_cnt     <= 8'd0;
      period_cnt  <= 6'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
      period_tick <= 1'b0;
      wave_out    <= 8'd0;
    end else begin
      if (cfg_we) begin
        prog[cfg_addr] <= cfg_data;
      end

      state    <= next_state;
      slot_idx <= next_slot;
      // Decoded from next_state so busy/done line up with the state they describe.
      busy     <= (next_state == LOAD) || (next_state == RUN);
      done     <= (next_state == DONE);

      period_tick <= (state == RUN) && !stop && wrap;
      wave_out    <= ((state == RUN) && !stop) ? shape : 8'd0;

      if (state == LOAD) begin
        wave_sel   <= load_word[15:14];
        rep        <= load_word[13:8];
        div        <= load_word[7:0];
        phase      <= 8'd0;
        div_cnt    <= 8'd0;
        period_cnt <= 6'd0;
      end else if (state == RUN) begin
        if (step_en) begin
          div_cnt <= 8'd0;
          phase   <= phase + 8'd1;
          if (wrap) begin
            period_cnt <= period_cnt + 6'd1;
          end
        end else begin
          div_cnt <= div_cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_wave_sequencer.sv
// tb/tb_wave_sequencer.sv - self-checking bench for wave_sequencer against a slot-level reference model
module tb_wave_sequencer;

  localparam int DEPTH = 4;
  localparam int IDX_W = 2;
  localparam int KL = 0;
  localparam int KR = 1;
  localparam int KD = 2;

  typedef struct {
    int kind;
    int slot;
    int sel;
    int phase;
    bit last;
  } ent_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cfg_we = 1'b0;
  logic [IDX_W-1:0] cfg_addr = '0;
  logic [15:0]      cfg_data = 16'd0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             loop = 1'b0;
  logic             busy;
  logic             done;
  logic [IDX_W-1:0] slot_idx;
  logic             period_tick;
  logic [7:0]       wave_out;

  int          n_check = 0;
  int          n_pass = 0;
  ent_t        exp_q[$];
  logic [12:0] obs_q[$];
  logic [15:0] shadow [DEPTH];

  wave_sequencer #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .start(start), .stop(stop), .loop(loop), .busy(busy), .done(done),
    .slot_idx(slot_idx), .period_tick(period_tick), .wave_out(wave_out)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Observed word layout: [12] busy, [11] done, [10] period_tick, [9:8] slot_idx, [7:0] wave_out
  function automatic logic [12:0] pack_obs();
    return {busy, done, period_tick, slot_idx, wave_out};
  endfunction

  function automatic int shape_of(input int sel, input int p);
    case (sel)
      0:       return 0;
      1:       return (p >= 128) ? 255 : 0;
      2:       return p;
      default: return (p > 128) ? 256 - p : p;
    endcase
  endfunction

  task automatic write_slot(input int a, input logic [15:0] w);
    cfg_we   = 1'b1;
    cfg_addr = IDX_W'(a);
    cfg_data = w;
    step();
    cfg_we   = 1'b0;
    shadow[a] = w;
  endtask

  task automatic clear_prog();
    for (int i = 0; i < DEPTH; i++) write_slot(i, 16'd0);
  endtask

  function automatic logic [15:0] slot_word(input int sel, input int r, input int dv);
    return {sel[1:0], r[5:0], dv[7:0]};
  endfunction

  // Reference: one entry per cycle the program spends in LOAD, RUN (per phase and divider count) or DONE.
  task automatic build(input bit lp, input int limit);
    int s;
    int rp;
    int dv;
    int sel;
    logic [15:0] w;
    ent_t e;
    exp_q.delete();
    s = 0;
    while (exp_q.size() < limit) begin
      w   = shadow[s];
      sel = int'(w[15:14]);
      rp  = int'(w[13:8]);
      dv  = int'(w[7:0]);
      e = '{KL, s, sel, 0, 1'b0};
      exp_q.push_back(e);
      for (int r = 0; r < rp; r++)
        for (int p = 0; p < 256; p++)
          for (int d = 0; d <= dv; d++) begin
            e = '{KR, s, sel, p, (p == 255 && d == dv)};
            exp_q.push_back(e);
          end
      if (s == DEPTH - 1) begin
        if (lp) s = 0;
        else begin
          e = '{KD, s, sel, 0, 1'b0};
          exp_q.push_back(e);
          break;
        end
      end else begin
        s++;
      end
    end
  endtask

  // Outputs are registered: wave_out and period_tick reflect the previous cycle's RUN position.
  function automatic logic [12:0] exp_word(input int k);
    logic       b;
    logic       d;
    logic       t;
    logic [1:0] sl;
    logic [7:0] w;
    int         n;
    n = exp_q.size();
    if (k < n) begin
      b  = (exp_q[k].kind != KD);
      d  = (exp_q[k].kind == KD);
      sl = 2'(exp_q[k].slot);
    end else begin
      b  = 1'b0;
      d  = 1'b0;
      sl = 2'(exp_q[n-1].slot);
    end
    w = 8'd0;
    t = 1'b0;
    if (k > 0 && k - 1 < n && exp_q[k-1].kind == KR) begin
      w = 8'(shape_of(exp_q[k-1].sel, exp_q[k-1].phase));
      t = exp_q[k-1].last;
    end
    return {b, d, t, sl, w};
  endfunction

  task automatic collect(input int n, input int stop_k);
    obs_q.delete();
    start = 1'b1;
    for (int k = 0; k < n; k++) begin
      step();
      start = 1'b0;
      stop  = (k == stop_k);
      obs_q.push_back(pack_obs());
    end
    stop = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    n_check++;
    if (pack_obs() !== 13'd0) $display("FAIL reset_state: got %h want %h", pack_obs(), 13'd0);
    else n_pass++;
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) shadow[i] = 16'd0;
    step();
    n_check++;
    if (pack_obs() !== 13'd0) $display("FAIL idle_after_reset: got %h want %h", pack_obs(), 13'd0);
    else n_pass++;
  endtask

  task automatic test_saw();
    int ndone;
    clear_prog();
    write_slot(0, slot_word(2, 1, 0));
    build(1'b0, 1 << 20);
    collect(exp_q.size() + 2, -1);
    for (int k = 0; k < obs_q.size(); k++) begin
      n_check++;
      if (obs_q[k] !== exp_word(k)) $display("FAIL saw cycle %0d: got %h want %h", k, obs_q[k], exp_word(k));
      else n_pass++;
    end
    n_check++;
    if (obs_q[0][12] !== 1'b1) $display("FAIL saw_busy_rise: got %b want 1", obs_q[0][12]);
    else n_pass++;
    n_check++;
    if (obs_q[257][7:0] !== 8'd255) $display("FAIL saw_last_sample: got %0d want 255", obs_q[257][7:0]);
    else n_pass++;
    ndone = 0;
    foreach (obs_q[k]) if (obs_q[k][11]) ndone++;
    n_check++;
    if (ndone != 1) $display("FAIL saw_done_count: got %0d want 1", ndone);
    else n_pass++;
  endtask

  task automatic test_tri();
    int ticks[$];
    int peak;
    clear_prog();
    write_slot(0, slot_word(3, 2, 1));
    build(1'b0, 1 << 20);
    collect(exp_q.size() + 2, -1);
    for (int k = 0; k < obs_q.size(); k++) begin
      n_check++;
      if (obs_q[k] !== exp_word(k)) $display("FAIL tri cycle %0d: got %h want %h", k, obs_q[k], exp_word(k));
      else n_pass++;
    end
    peak = 0;
    foreach (obs_q[k]) begin
      if (obs_q[k][10]) ticks.push_back(k);
      if (int'(obs_q[k][7:0]) > peak) peak = int'(obs_q[k][7:0]);
    end
    n_check++;
    if (ticks.size() != 2) $display("FAIL tri_tick_count: got %0d want 2", ticks.size());
    else n_pass++;
    n_check++;
    if (ticks.size() == 2 && ticks[1] - ticks[0] != 512)
      $display("FAIL tri_tick_spacing: got %0d want 512", ticks[1] - ticks[0]);
    else if (ticks.size() == 2) n_pass++;
    else $display("FAIL tri_tick_spacing: got no pair want 512");
    n_check++;
    if (peak != 128) $display("FAIL tri_peak: got %0d want 128", peak);
    else n_pass++;
  endtask

  task automatic test_square_saw();
    clear_prog();
    write_slot(0, slot_word(1, 1, 0));
    write_slot(1, slot_word(2, 1, 0));
    build(1'b0, 1 << 20);
    collect(exp_q.size() + 2, -1);
    for (int k = 0; k < obs_q.size(); k++) begin
      n_check++;
      if (obs_q[k] !== exp_word(k)) $display("FAIL square_saw cycle %0d: got %h want %h", k, obs_q[k], exp_word(k));
      else n_pass++;
    end
  endtask

  task automatic test_loop();
    int n;
    clear_prog();
    for (int i = 0; i < DEPTH; i++) write_slot(i, slot_word($urandom_range(0, 3), 1, 0));
    loop = 1'b1;
    n = DEPTH * 257 + 200;
    build(1'b1, n);
    collect(n, -1);
    for (int k = 0; k < n; k++) begin
      n_check++;
      if (obs_q[k] !== exp_word(k)) $display("FAIL loop cycle %0d: got %h want %h", k, obs_q[k], exp_word(k));
      else n_pass++;
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    loop = 1'b0;
    n_check++;
    if (busy !== 1'b0) $display("FAIL loop_stop_busy: got %b want 0", busy);
    else n_pass++;
    step();
  endtask

  task automatic test_stop();
    int stop_k;
    logic [12:0] idle_w;
    clear_prog();
    write_slot(0, slot_word(2, 3, 0));
    build(1'b0, 1 << 20);
    stop_k = -1;
    foreach (exp_q[k]) if (stop_k < 0 && exp_q[k].kind == KR && exp_q[k].phase == 100) stop_k = k;
    collect(stop_k + 3, stop_k);
    for (int k = 0; k <= stop_k; k++) begin
      n_check++;
      if (obs_q[k] !== exp_word(k)) $display("FAIL stop_pre cycle %0d: got %h want %h", k, obs_q[k], exp_word(k));
      else n_pass++;
    end
    idle_w = {3'b000, 2'(exp_q[stop_k].slot), 8'd0};
    for (int k = stop_k + 1; k < stop_k + 3; k++) begin
      n_check++;
      if (obs_q[k] !== idle_w) $display("FAIL stop_idle cycle %0d: got %h want %h", k, obs_q[k], idle_w);
      else n_pass++;
    end
    start = 1'b1;
    stop  = 1'b1;
    step();
    start = 1'b0;
    stop  = 1'b0;
    for (int k = 0; k < 2; k++) begin
      n_check++;
      if (busy !== 1'b0 || wave_out !== 8'd0)
        $display("FAIL start_stop_idle cycle %0d: got busy %b wave %0d want busy 0 wave 0", k, busy, wave_out);
      else n_pass++;
      step();
    end
  endtask

  task automatic test_rst_midrun();
    clear_prog();
    write_slot(0, slot_word(2, 2, 0));
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (40) step();
    rst = 1'b1;
    step();
    n_check++;
    if (pack_obs() !== 13'd0) $display("FAIL rst_midrun_state: got %h want %h", pack_obs(), 13'd0);
    else n_pass++;
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) shadow[i] = 16'd0;
    build(1'b0, 1 << 20);
    collect(exp_q.size() + 2, -1);
    for (int k = 0; k < obs_q.size(); k++) begin
      n_check++;
      if (obs_q[k] !== exp_word(k)) $display("FAIL rst_skip cycle %0d: got %h want %h", k, obs_q[k], exp_word(k));
      else n_pass++;
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      for (int i = 0; i < DEPTH; i++)
        write_slot(i, slot_word($urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 2)));
      build(1'b0, 1 << 20);
      collect(exp_q.size() + 2, -1);
      for (int k = 0; k < obs_q.size(); k++) begin
        n_check++;
        if (obs_q[k] !== exp_word(k))
          $display("FAIL random%0d cycle %0d: got %h want %h", it, k, obs_q[k], exp_word(k));
        else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_saw();
    test_tri();
    test_square_saw();
    test_loop();
    test_stop();
    test_rst_midrun();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_check);
    $finish;
  end

endmodule
